// File: rtl/mod_reduce_if.sv
// rtl/mod_reduce_if.sv - mod_enable/mod_done handshake bundle between initiator and reducer
interface mod_reduce_if #(
  parameter int IN_W = 128
);
  logic            mod_enable;
  logic [IN_W-1:0] mod_input;
  logic            mod_input_sign;
  logic            mod_done;
  logic [63:0]     mod_result;
  logic            busy;

  modport master (
    output mod_enable, mod_input, mod_input_sign,
    input  mod_done, mod_result, busy
  );

  modport slave (
    input  mod_enable, mod_input, mod_input_sign,
    output mod_done, mod_result, busy
  );
endinterface

// File: rtl/mod_reduce.sv
// rtl/mod_reduce.sv - signed 128-bit operand reduced mod a fixed 64-bit prime by restoring long division
// Optional MOD_REDUCE_RADIX4_EN: retire two dividend bits per RUN cycle instead of one.
module mod_reduce #(
  parameter logic [63:0] MODULUS = 64'd10997031918897188677,
  parameter int          IN_W    = 128
) (
  input  logic         clk,
  input  logic         rst,
  mod_reduce_if.slave  bus
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;

  localparam int CW = $clog2(IN_W);
`ifdef MOD_REDUCE_RADIX4_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam logic [CW-1:0] LAST_CNT = CW'(IN_W / STEP - 1);
  localparam logic [64:0]   P65      = {1'b0, MODULUS};

  logic [1:0]      state;
  logic [IN_W-1:0] sreg;
  logic [IN_W-1:0] sreg_next;
  logic [64:0]     r;
  logic [64:0]     r_next;
  logic [CW-1:0]   cnt;
  logic            sign;
  logic            done_q;
  logic [63:0]     result_q;

  // r stays below P, so shifting in one bit gives at most 2P-1 and one subtract restores it
  function automatic logic [64:0] csub(input logic [64:0] rem, input logic b);
    logic [64:0] t;
    t = {rem[63:0], b};
    return (t >= P65) ? (t - P65) : t;
  endfunction

  always_comb begin
    r_next    = r;
    sreg_next = sreg;
`ifdef MOD_REDUCE_RADIX4_EN
    r_next    = csub(csub(r, sreg[IN_W-1]), sreg[IN_W-2]);
    sreg_next = sreg << 2;
`else
    r_next    = csub(r, sreg[IN_W-1]);
    sreg_next = sreg << 1;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      sreg     <= '0;
      r        <= '0;
      cnt      <= '0;
      sign     <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      done_q <= 1'b0;
      // A start in any state wins; an operation in RUN or FIX is silently dropped
      if (bus.mod_enable) begin
        sreg  <= bus.mod_input;
        sign  <= bus.mod_input_sign;
        r     <= '0;
        cnt   <= '0;
        state <= RUN;
      end else begin
        case (state)
          IDLE: state <= IDLE;
          RUN: begin
            r    <= r_next;
            sreg <= sreg_next;
            cnt  <= cnt + 1'b1;
            if (cnt == LAST_CNT)
              state <= FIX;
          end
          FIX: begin
            if (!sign)
              result_q <= r[63:0];
            else
              result_q <= (r == '0) ? 64'd0 : (MODULUS - r[63:0]);
            done_q <= 1'b1;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.mod_done   = done_q;
  assign bus.mod_result = result_q;
  assign bus.busy       = (state != IDLE) || done_q;
endmodule

// File: tb/tb_mod_reduce.sv
// tb/tb_mod_reduce.sv - scoreboard bench for mod_reduce; latency follows MOD_REDUCE_RADIX4_EN
module tb_mod_reduce;
  localparam logic [63:0] P = 64'd10997031918897188677;
`ifdef MOD_REDUCE_RADIX4_EN
  localparam int LAT = 65;
`else
  localparam int LAT = 129;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;
  logic [63:0] sb_q[$];

  mod_reduce_if #(.IN_W(128)) bus ();
  mod_reduce #(.MODULUS(P), .IN_W(128)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.mod_done) done_cnt++;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [127:0] x, input logic s);
    logic [127:0] m;
    m = x % {64'd0, P};
    if (!s) return m[63:0];
    return (m == 0) ? 64'd0 : (P - m[63:0]);
  endfunction

  task automatic start(input logic [127:0] x, input logic s);
    @(negedge clk);
    bus.mod_enable     = 1'b1;
    bus.mod_input      = x;
    bus.mod_input_sign = s;
    @(posedge clk);
    #1 bus.mod_enable = 1'b0;
  endtask

  task automatic wait_done();
    int   lat;
    logic busy_ok;
    logic [63:0] exp;
    lat = -1;
    busy_ok = 1'b1;
    for (int i = 0; i < LAT + 20; i++) begin
      @(negedge clk);
      if (bus.mod_done) begin
        lat = i;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
    check("latency", 128'(lat), 128'(LAT));
    check("busy_run", {127'd0, busy_ok}, 128'd1);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 64'hx;
    if (lat >= 0) begin
      check("busy_done", {127'd0, bus.busy}, 128'd1);
      check("result", {64'd0, bus.mod_result}, {64'd0, exp});
    end
    @(negedge clk);
    check("done_pulse", {127'd0, bus.mod_done}, 128'd0);
    check("busy_idle", {127'd0, bus.busy}, 128'd0);
  endtask

  task automatic run_op(input logic [127:0] x, input logic s, input logic [63:0] exp);
    start(x, s);
    sb_q.push_back(exp);
    wait_done();
  endtask

  initial begin
    logic [127:0] pm1;
    logic [127:0] x;
    int d0;
    bus.mod_enable     = 1'b0;
    bus.mod_input      = '0;
    bus.mod_input_sign = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_done", {127'd0, bus.mod_done}, 128'd0);
    check("rst_busy", {127'd0, bus.busy}, 128'd0);
    check("rst_result", {64'd0, bus.mod_result}, 128'd0);
    rst = 1'b0;

    run_op(128'd5, 1'b0, 64'd5);
    run_op({64'd0, P}, 1'b0, 64'd0);
    run_op({64'd0, P} + 128'd3, 1'b0, 64'd3);
    pm1 = {64'd0, P - 64'd1};
    run_op(pm1 * pm1, 1'b0, 64'd1);
    x = '1;
    run_op(x, 1'b0, model(x, 1'b0));
    run_op(128'd1, 1'b1, 64'd10997031918897188676);
    run_op(128'd0, 1'b1, 64'd0);
    for (int i = 0; i < 3; i++) begin
      x = {$urandom, $urandom, $urandom, $urandom};
      run_op(x, i[0], model(x, i[0]));
    end

    // abort: restart mid-RUN, only the second operand completes
    start(128'd9, 1'b0);
    repeat (50) @(negedge clk);
    d0 = done_cnt;
    run_op(128'd7, 1'b0, 64'd7);
    check("abort_one_done", 128'(done_cnt - d0), 128'd1);

    // asynchronous reset mid-RUN
    start(128'd12345, 1'b0);
    repeat (60) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_done", {127'd0, bus.mod_done}, 128'd0);
    check("arst_busy", {127'd0, bus.busy}, 128'd0);
    check("arst_result", {64'd0, bus.mod_result}, 128'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    d0 = done_cnt;
    repeat (LAT + 10) @(negedge clk);
    check("no_done_after_rst", 128'(done_cnt - d0), 128'd0);
    check("busy_after_rst", {127'd0, bus.busy}, 128'd0);
    run_op({64'd0, P} + 128'd3, 1'b0, 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
